// File: rtl/logic_gate_pkg.sv
// Shared types and the bitwise evaluation function
// for the pipelined logic unit.
package logic_gate_pkg;

  localparam int MAX_W = 64;

  typedef enum logic [2:0] {
    OP_NOT  = 3'b000,
    OP_BUF  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_NAND = 3'b100,
    OP_NOR  = 3'b101,
    OP_XOR  = 3'b110,
    OP_XNOR = 3'b111
  } op_e;

  // Operates at MAX_W; callers truncate to their width.
  function automatic logic [MAX_W-1:0] eval_op(
    input op_e              op,
    input logic [MAX_W-1:0] a,
    input logic [MAX_W-1:0] b
  );
    logic [MAX_W-1:0] r;
    r = '0;
    unique case (op)
      OP_NOT:  r = ~a;
      OP_BUF:  r = a;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_XOR:  r = a ^ b;
      OP_XNOR: r = ~(a ^ b);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_gate_pipe_if.sv
// Operand and result valid/ready bundle of the
// pipelined logic unit.
interface logic_gate_pipe_if
  import logic_gate_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  op_e              op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] z;
  logic [CNT_W-1:0] ops_done;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, z, ops_done
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, z, ops_done
  );
endinterface

// File: rtl/logic_gate_pipe_stage.sv
// One valid/result register of the pipe; data is only
// replaced when a valid beat is loaded.
module pipe_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);
  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= i_valid;
      if (i_valid) r_data <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
endmodule

// File: rtl/logic_gate_pipe.sv
// WIDTH-bit bitwise logic unit with a STAGES-deep
// bubble-collapsing result pipeline and a done counter.
module logic_gate_pipe
  import logic_gate_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input logic         clk,
  input logic         rst_n,
  logic_gate_pipe_if.slave bus
);
  logic [STAGES-1:0] w_valid;
  logic [STAGES-1:0] w_adv;
  logic [STAGES-1:0] w_up_valid;
  logic [WIDTH-1:0]  w_data    [STAGES];
  logic [WIDTH-1:0]  w_up_data [STAGES];
  logic [WIDTH-1:0]  w_res;
  logic              w_tail;
  logic [CNT_W-1:0]  r_ops_done;

  assign w_res = WIDTH'(eval_op(bus.op,
                                MAX_W'(bus.a),
                                MAX_W'(bus.b)));

  // Stage k may load unless it and every stage
  // below it are full while the output is stalled.
  always_comb begin
    w_adv  = '0;
    w_tail = 1'b1;
    for (int k = STAGES - 1; k >= 0; k--) begin
      w_tail   = w_tail & w_valid[k];
      w_adv[k] = !w_tail || bus.out_ready;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign w_up_valid[k] = bus.in_valid;
      assign w_up_data[k]  = w_res;
    end else begin : g_body
      assign w_up_valid[k] = w_valid[k-1];
      assign w_up_data[k]  = w_data[k-1];
    end

    pipe_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_load (w_adv[k]),
      .i_valid(w_up_valid[k]),
      .i_data (w_up_data[k]),
      .o_valid(w_valid[k]),
      .o_data (w_data[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ops_done <= '0;
    end else if (bus.out_valid && bus.out_ready) begin
      r_ops_done <= r_ops_done + 1'b1;
    end
  end

  assign bus.in_ready  = w_adv[0];
  assign bus.out_valid = w_valid[STAGES-1];
  assign bus.z         = w_data[STAGES-1];
  assign bus.ops_done  = r_ops_done;
endmodule

// File: tb/tb_logic_gate_pipe.sv
// Scoreboard bench for logic_gate_pipe: drivers push
// expected results, a monitor pops on every handshake.
module tb_logic_gate_pipe;
  import logic_gate_pkg::*;

  localparam int W  = 8;
  localparam int S  = 2;
  localparam int CW = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic_gate_pipe_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  logic_gate_pipe #(
    .WIDTH (W),
    .STAGES(S),
    .CNT_W (CW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_vec   = 0;
  int n_err   = 0;
  int n_acc   = 0;
  int n_stall = 0;

  logic [W-1:0]  exp_q [$];
  logic [CW-1:0] exp_cnt = '0;
  logic          mon_pstall = 1'b0;
  logic [W-1:0]  mon_pz = '0;
  logic          rnd_done = 1'b0;

  logic [W-1:0] sweep_tbl [8] = '{
    8'h0F, 8'hF0, 8'hC0, 8'hFC,
    8'h3F, 8'h03, 8'h3C, 8'hC3
  };

  function automatic logic [W-1:0] ref_op(
    input int unsigned op,
    input logic [W-1:0] a,
    input logic [W-1:0] b
  );
    case (op)
      0:       return ~a;
      1:       return a;
      2:       return a & b;
      3:       return a | b;
      4:       return ~(a & b);
      5:       return ~(a | b);
      6:       return a ^ b;
      default: return ~(a ^ b);
    endcase
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               nm, act, exp, $time);
    end
  endtask

  // Call at posedge+1; returns at posedge+1 after transfer.
  task automatic send(input int unsigned op,
                      input logic [W-1:0] a,
                      input logic [W-1:0] b,
                      input logic [W-1:0] e);
    int unsigned o3;
    int t;
    t  = 0;
    o3 = op & 32'd7;
    bus.in_valid = 1'b1;
    bus.op = op_e'(o3[2:0]);
    bus.a  = a;
    bus.b  = b;
    @(negedge clk);
    while (!bus.in_ready && t < 100) begin
      n_stall++;
      t++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: in_ready stuck 0");
    end else begin
      exp_q.push_back(e);
      n_acc++;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_rnd();
    int unsigned op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    op = $urandom_range(0, 7);
    a  = W'($urandom);
    b  = W'($urandom);
    send(op, a, b, ref_op(op, a, b));
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: %0d left", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_pstall = 1'b0;
      end else begin
        if (mon_pstall) begin
          chk("stall_valid", 32'(bus.out_valid), 32'd1);
          chk("stall_z", 32'(bus.z), 32'(mon_pz));
        end
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL spurious: z=%0h", bus.z);
          end else begin
            chk("z", 32'(bus.z), 32'(exp_q.pop_front()));
          end
          chk("ops_done", 32'(bus.ops_done), 32'(exp_cnt));
          exp_cnt = exp_cnt + 1'b1;
        end
        mon_pstall = bus.out_valid && !bus.out_ready;
        mon_pz     = bus.z;
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation hung");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int a0;
    int s0;
    logic [CW-1:0] c0;
    bus.in_valid  = 1'b0;
    bus.op        = OP_NOT;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;

    #1 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_z", 32'(bus.z), 32'd0);
    chk("rst_ops_done", 32'(bus.ops_done), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", 32'(bus.in_ready), 32'd1);
    chk("idle_out_valid", 32'(bus.out_valid), 32'd0);

    // single NOT beat and its latency
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    send(0, 8'hA5, 8'h00, 8'h5A);
    @(negedge clk);
    chk("lat_early", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk("lat_valid", 32'(bus.out_valid), 32'd1);
    chk("lat_z", 32'(bus.z), 32'h5A);
    drain();
    chk("not_ops_done", 32'(bus.ops_done), 32'd1);

    // all ops back to back
    s0 = n_stall;
    for (int i = 0; i < 8; i++)
      send(i, 8'hF0, 8'hCC, sweep_tbl[i]);
    chk("sweep_no_stall", n_stall - s0, 32'd0);
    drain();

    // backpressure
    bus.out_ready = 1'b0;
    a0 = n_acc;
    c0 = exp_cnt;
    fork
      begin
        for (int i = 0; i < 4; i++) send_rnd();
      end
      begin
        repeat (6) @(negedge clk);
        chk("bp_accepted", n_acc - a0, 32'd2);
        chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_ops_done", 32'(bus.ops_done),
        32'(CW'(c0 + CW'(4))));

    // reset with two beats in flight
    bus.out_ready = 1'b0;
    send_rnd();
    send_rnd();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_z", 32'(bus.z), 32'd0);
    exp_q.delete();
    exp_cnt = '0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_rst_ops", 32'(bus.ops_done), 32'd0);
    chk("post_rst_valid", 32'(bus.out_valid), 32'd0);

    // counter wrap at CNT_W=4
    @(posedge clk);
    #1;
    for (int i = 0; i < 15; i++) send_rnd();
    drain();
    chk("wrap_15", 32'(bus.ops_done), 32'd15);
    send_rnd();
    drain();
    chk("wrap_0", 32'(bus.ops_done), 32'd0);
    send_rnd();
    drain();
    chk("wrap_1", 32'(bus.ops_done), 32'd1);

    // random traffic with random backpressure
    fork
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1 bus.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
      begin
        for (int i = 0; i < 200; i++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          send_rnd();
        end
        rnd_done = 1'b1;
      end
    join
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    drain();
    chk("final_ops", 32'(bus.ops_done), 32'(exp_cnt));

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/logic_gate_pipe.md
Name: logic_gate_pipe

Overview:
- Parametrised, clocked successor to the single-bit NOT gate: a WIDTH-bit bitwise logic unit with selectable operation.
- The evaluation delay is a STAGES-deep register pipeline instead of a fixed propagation delay.
- Operands enter through a valid/ready handshake. Results leave through a second valid/ready handshake with full backpressure.
- Used in lab datapaths wherever a gate-level operation must be applied to a word stream.

Parameters:
- WIDTH, 8, operand and result width in bits (≥1).
- STAGES, 2, pipeline depth and hence latency in cycles (≥1).
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand beat offered.
- in_ready  output  1  unit accepts the beat this cycle.
- op  input  3  operation select, sampled with the operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B; ignored for NOT and BUF.
- out_valid  output  1  result beat offered.
- out_ready  input  1  downstream accepts the result.
- z  output  WIDTH  result.
- ops_done  output  CNT_W  count of results consumed.

Behaviour:
- Reset: asynchronous, active-low, on rst_n low with no clock needed.
  - All stage valid bits clear, so out_valid=0.
  - z=0, ops_done=0, all stage data registers 0.
  - in_ready=1 from the first cycle after release.
- Reset mid-operation: in-flight beats are discarded and none are later emitted. ops_done returns to 0.
- op encoding (bitwise over all WIDTH bits):
  - 000 NOT a; 001 BUF a.
  - 010 AND; 011 OR; 100 NAND; 101 NOR; 110 XOR; 111 XNOR.
- Input transfer happens when in_valid && in_ready. The result is computed combinationally from the captured a, b, op and registered into stage 0. Only results travel down the pipe, not operands.
- Stage k (0..STAGES-1) holds a valid bit and a WIDTH-bit result. The last stage drives out_valid and z.
- Advance rule, where adv_k is true when stage k may load:
  - Last stage: adv = !valid_last || out_ready.
  - Other stages: adv_k = !valid_k || adv_{k+1}.
  - in_ready = adv_0. This is bubble-collapsing: a full pipe with out_ready=1 accepts a new beat every cycle.
- When a stage loads, it takes the upstream valid and data. A stage whose upstream is empty loads valid=0 and keeps its old data.
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+STAGES-1, i.e. it is visible during the following cycle, provided there is no stall.
- Throughput is 1 beat per cycle when out_ready is held at 1.
- Stall: while out_valid && !out_ready, z and out_valid stay stable. Upstream stages fill, then in_ready drops. The pipe holds at most STAGES beats and never drops or duplicates a beat.
- Simultaneous accept and emit on a full pipe is legal: occupancy stays unchanged.
- ops_done increments by 1 on each out_valid && out_ready and wraps from 2^CNT_W-1 to 0.
- in_valid must not depend on in_ready. Beats are not required to stay stable when not accepted, because the unit samples only on transfer.

Decomposition:
- Shared package logic_gate_pkg:
  - typedef enum logic [2:0] op_e with OP_NOT, OP_BUF, OP_AND, OP_OR, OP_NAND, OP_NOR, OP_XOR, OP_XNOR.
  - Pure function eval_op(op_e, a, b), parameterised by width through a local typedef or a width argument. The bench reuses it as the reference model.
- Sub-module pipe_stage: one valid/data register with load enable and async reset, instantiated STAGES times in a generate loop. The top level holds the advance chain, the op evaluation and the counter.

Test Plan:
- Reset then idle (WIDTH=8, STAGES=2): out_valid=0, z=8'h00, ops_done=0, and in_ready=1 on the cycle after rst_n rises.
- op=NOT, a=8'hA5, single beat, out_ready=1: out_valid rises 2 cycles after acceptance with z=8'h5A, and ops_done becomes 1 after the handshake.
- Sweep all 8 ops with a=8'hF0, b=8'hCC, back-to-back with out_ready=1.
  - Expected z sequence: 0F, F0, C0, FC, 3F, 03, 3C, C3.
  - One beat per cycle, in order.
- Backpressure: hold out_ready=0 while streaming 4 beats.
  - in_ready drops after 2 accepted beats and z stays stable.
  - Releasing out_ready drains the beats in order with no loss; ops_done increases by exactly the number accepted.
- Reset mid-operation: assert rst_n=0 asynchronously between edges with 2 beats in flight.
  - out_valid and z drop immediately.
  - After release, no stale beat appears and ops_done=0.
- Counter wrap (CNT_W=4): consume 17 results; ops_done reads 15 then 0 then 1.
